// File: rtl/imem_fetch_ctrl.sv
// Fetch PC owner: one outstanding imem read, returned word held for decode until INSTR_READY (stalls hold PC).
// Best case 3 cycles/instr (REQ, WAIT, HOLD); IMEM_FETCH_MISALIGN_EN adds the misaligned-redirect FAULT state.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic        INSTR_VALID,
  output logic [31:0] INSTR,
  output logic [31:0] INSTR_PC,
  input  logic        INSTR_READY,
  output logic [31:0] PC,
  output logic        MISALIGN
);

`ifdef IMEM_FETCH_MISALIGN_EN
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_FAULT} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;
`endif

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] redirect_tgt;
  logic [31:0] instr_q, instr_pc_q;
  logic        drop, drop_nxt;
  logic        load_instr;

`ifdef IMEM_FETCH_MISALIGN_EN
  assign redirect_tgt = REDIRECT_PC;
`else
  assign redirect_tgt = REDIRECT_PC & 32'hFFFF_FFFC;
`endif

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    drop_nxt   = drop;
    load_instr = 1'b0;
    if (REDIRECT) pc_nxt = redirect_tgt;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        // A grant in the redirect cycle was issued at the old PC; its response must be discarded.
        if (IMEM_GNT) begin
          state_nxt = S_WAIT;
          drop_nxt  = REDIRECT;
        end
      end
      S_WAIT: begin
        if (IMEM_RVALID) begin
          if (drop || REDIRECT) begin
            state_nxt = S_REQ;
            drop_nxt  = 1'b0;
          end else begin
            state_nxt  = S_HOLD;
            load_instr = 1'b1;
          end
        end else if (REDIRECT) begin
          drop_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (REDIRECT || INSTR_READY) begin
          state_nxt = S_REQ;
          if (!REDIRECT) pc_nxt = pc + 32'd4;
        end
      end
`ifdef IMEM_FETCH_MISALIGN_EN
      S_FAULT: if (REDIRECT) state_nxt = S_REQ;
`endif
      default: state_nxt = S_IDLE;
    endcase
`ifdef IMEM_FETCH_MISALIGN_EN
    // Any path that would issue a request at a misaligned PC parks in FAULT instead.
    if (state_nxt == S_REQ && pc_nxt[1:0] != 2'b00) state_nxt = S_FAULT;
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      drop  <= drop_nxt;
      if (load_instr) begin
        instr_q    <= IMEM_RDATA;
        instr_pc_q <= pc;
      end
    end
  end

  assign IMEM_REQ    = (state == S_REQ);
  assign IMEM_ADDR   = pc;
  assign INSTR_VALID = (state == S_HOLD);
  assign INSTR       = instr_q;
  assign INSTR_PC    = instr_pc_q;
  assign PC          = pc;
`ifdef IMEM_FETCH_MISALIGN_EN
  assign MISALIGN    = (state == S_FAULT);
`else
  assign MISALIGN    = 1'b0;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: cycle-exact memory/decode stimulus with a scoreboard of expected deliveries.
module tb_imem_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT;
  logic        IMEM_RVALID;
  logic [31:0] IMEM_RDATA;
  logic        INSTR_VALID;
  logic [31:0] INSTR;
  logic [31:0] INSTR_PC;
  logic        INSTR_READY;
  logic [31:0] PC;
  logic        MISALIGN;

  int tests_run = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  imem_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .RST_N(RST_N), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_GNT(IMEM_GNT),
    .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
    .INSTR_VALID(INSTR_VALID), .INSTR(INSTR), .INSTR_PC(INSTR_PC),
    .INSTR_READY(INSTR_READY), .PC(PC), .MISALIGN(MISALIGN)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0001 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Grant in the current REQ cycle, return the word one cycle later.
  task automatic serve(input logic [31:0] a, input bit push);
    IMEM_GNT = 1'b1;
    if (push) exp_q.push_back({a, mem_word(a)});
    tick();
    IMEM_GNT = 1'b0;
    IMEM_RVALID = 1'b1;
    IMEM_RDATA = mem_word(a);
    tick();
    IMEM_RVALID = 1'b0;
    IMEM_RDATA = 32'h0;
  endtask

  task automatic test_reset();
    tests_run++; if (IMEM_REQ !== 1'b0) begin fails++; $display("FAIL reset_req got %b exp 0", IMEM_REQ); end
    tests_run++; if (IMEM_ADDR !== 32'h0) begin fails++; $display("FAIL reset_addr got %h exp 0", IMEM_ADDR); end
    tests_run++; if (INSTR_VALID !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", INSTR_VALID); end
    tests_run++; if (INSTR !== 32'h0 || INSTR_PC !== 32'h0) begin fails++; $display("FAIL reset_instr got %h@%h exp 0@0", INSTR, INSTR_PC); end
    tests_run++; if (MISALIGN !== 1'b0 || PC !== 32'h0) begin fails++; $display("FAIL reset_pc got pc %h mis %b exp 0 0", PC, MISALIGN); end
    RST_N = 1'b1;
    tests_run++; if (IMEM_REQ !== 1'b0) begin fails++; $display("FAIL idle_req got %b exp 0", IMEM_REQ); end
    tick();
    tests_run++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h0) begin fails++; $display("FAIL first_req got %b@%h exp 1@0", IMEM_REQ, IMEM_ADDR); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = 32'(i * 4);
      tests_run++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== a) begin fails++; $display("FAIL stream_req got %b@%h exp 1@%h", IMEM_REQ, IMEM_ADDR, a); end
      tests_run++; if (INSTR_VALID !== 1'b0) begin fails++; $display("FAIL stream_valid_req got %b exp 0", INSTR_VALID); end
      IMEM_GNT = 1'b1;
      exp_q.push_back({a, mem_word(a)});
      tick();
      IMEM_GNT = 1'b0;
      tests_run++; if (IMEM_REQ !== 1'b0 || INSTR_VALID !== 1'b0) begin fails++; $display("FAIL stream_wait got req %b vld %b exp 0 0", IMEM_REQ, INSTR_VALID); end
      IMEM_RVALID = 1'b1;
      IMEM_RDATA = mem_word(a);
      tick();
      IMEM_RVALID = 1'b0;
      tests_run++; if (INSTR_VALID !== 1'b1) begin fails++; $display("FAIL stream_valid got %b exp 1", INSTR_VALID); end
      tests_run++;
      if (exp_q.size() == 0) begin fails++; $display("FAIL stream_sb got empty queue exp entry"); end
      else begin e = exp_q.pop_front(); if (INSTR !== e.ins || INSTR_PC !== e.pc) begin fails++; $display("FAIL stream_instr got %h@%h exp %h@%h", INSTR, INSTR_PC, e.ins, e.pc); end end
      INSTR_READY = 1'b1;
      tick();
      INSTR_READY = 1'b0;
    end
    tests_run++; if (IMEM_ADDR !== 32'h10 || PC !== 32'h10) begin fails++; $display("FAIL stream_end got %h/%h exp 10", IMEM_ADDR, PC); end
  endtask

  task automatic test_hold_stall();
    serve(32'h10, 1'b1);
    tests_run++;
    if (exp_q.size() == 0) begin fails++; $display("FAIL stall_sb got empty queue exp entry"); end
    else begin e = exp_q.pop_front(); if (INSTR !== e.ins || INSTR_PC !== e.pc) begin fails++; $display("FAIL stall_instr got %h@%h exp %h@%h", INSTR, INSTR_PC, e.ins, e.pc); end end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++; if (INSTR_VALID !== 1'b1 || IMEM_REQ !== 1'b0) begin fails++; $display("FAIL stall_ctl cyc %0d got vld %b req %b exp 1 0", i, INSTR_VALID, IMEM_REQ); end
      tests_run++; if (INSTR !== e.ins || INSTR_PC !== e.pc) begin fails++; $display("FAIL stall_stable cyc %0d got %h@%h exp %h@%h", i, INSTR, INSTR_PC, e.ins, e.pc); end
    end
    INSTR_READY = 1'b1;
    tick();
    INSTR_READY = 1'b0;
    tests_run++; if (INSTR_VALID !== 1'b0 || IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h14) begin fails++; $display("FAIL stall_release got vld %b req %b addr %h exp 0 1 14", INSTR_VALID, IMEM_REQ, IMEM_ADDR); end
  endtask

  task automatic test_redirect_wait();
    IMEM_GNT = 1'b1;
    tick();
    IMEM_GNT = 1'b0;
    REDIRECT = 1'b1;
    REDIRECT_PC = 32'h100;
    tick();
    REDIRECT = 1'b0;
    tests_run++; if (PC !== 32'h100 || IMEM_REQ !== 1'b0) begin fails++; $display("FAIL rdw_pc got pc %h req %b exp 100 0", PC, IMEM_REQ); end
    tick();
    tick();
    tests_run++; if (IMEM_REQ !== 1'b0 || INSTR_VALID !== 1'b0) begin fails++; $display("FAIL rdw_pending got req %b vld %b exp 0 0", IMEM_REQ, INSTR_VALID); end
    IMEM_RVALID = 1'b1;
    IMEM_RDATA = 32'hDEAD_BEEF;
    tick();
    IMEM_RVALID = 1'b0;
    tests_run++; if (INSTR_VALID !== 1'b0) begin fails++; $display("FAIL rdw_stale got vld %b exp 0", INSTR_VALID); end
    tests_run++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h100) begin fails++; $display("FAIL rdw_newreq got %b@%h exp 1@100", IMEM_REQ, IMEM_ADDR); end
    serve(32'h100, 1'b1);
    tests_run++;
    if (exp_q.size() == 0) begin fails++; $display("FAIL rdw_sb got empty queue exp entry"); end
    else begin e = exp_q.pop_front(); if (INSTR_VALID !== 1'b1 || INSTR !== e.ins || INSTR_PC !== e.pc) begin fails++; $display("FAIL rdw_instr got %b %h@%h exp 1 %h@%h", INSTR_VALID, INSTR, INSTR_PC, e.ins, e.pc); end end
    INSTR_READY = 1'b1;
    tick();
    INSTR_READY = 1'b0;
    tests_run++; if (IMEM_ADDR !== 32'h104) begin fails++; $display("FAIL rdw_next got %h exp 104", IMEM_ADDR); end
  endtask

  task automatic test_redirect_gnt();
    REDIRECT = 1'b1;
    REDIRECT_PC = 32'h8;
    tick();
    REDIRECT = 1'b0;
    tests_run++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h8) begin fails++; $display("FAIL rdq_req got %b@%h exp 1@8", IMEM_REQ, IMEM_ADDR); end
    IMEM_GNT = 1'b1;
    REDIRECT = 1'b1;
    REDIRECT_PC = 32'h200;
    tick();
    IMEM_GNT = 1'b0;
    REDIRECT = 1'b0;
    tests_run++; if (IMEM_REQ !== 1'b0 || PC !== 32'h200) begin fails++; $display("FAIL rdg_wait got req %b pc %h exp 0 200", IMEM_REQ, PC); end
    IMEM_RVALID = 1'b1;
    IMEM_RDATA = mem_word(32'h8);
    tick();
    IMEM_RVALID = 1'b0;
    tests_run++; if (INSTR_VALID !== 1'b0 || IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h200) begin fails++; $display("FAIL rdg_drop got vld %b req %b addr %h exp 0 1 200", INSTR_VALID, IMEM_REQ, IMEM_ADDR); end
    serve(32'h200, 1'b1);
    tests_run++;
    if (exp_q.size() == 0) begin fails++; $display("FAIL rdg_sb got empty queue exp entry"); end
    else begin e = exp_q.pop_front(); if (INSTR_VALID !== 1'b1 || INSTR !== e.ins || INSTR_PC !== e.pc) begin fails++; $display("FAIL rdg_instr got %b %h@%h exp 1 %h@%h", INSTR_VALID, INSTR, INSTR_PC, e.ins, e.pc); end end
    INSTR_READY = 1'b1;
    REDIRECT = 1'b1;
    REDIRECT_PC = 32'h200;
    tick();
    INSTR_READY = 1'b0;
    REDIRECT = 1'b0;
    tests_run++; if (PC !== 32'h200 || INSTR_VALID !== 1'b0 || IMEM_REQ !== 1'b1) begin fails++; $display("FAIL rdg_accept got pc %h vld %b req %b exp 200 0 1", PC, INSTR_VALID, IMEM_REQ); end
    serve(32'h200, 1'b1);
    tests_run++;
    if (exp_q.size() == 0) begin fails++; $display("FAIL rdh_sb got empty queue exp entry"); end
    else begin e = exp_q.pop_front(); if (INSTR_VALID !== 1'b1 || INSTR !== e.ins || INSTR_PC !== e.pc) begin fails++; $display("FAIL rdh_instr got %b %h@%h exp 1 %h@%h", INSTR_VALID, INSTR, INSTR_PC, e.ins, e.pc); end end
    REDIRECT = 1'b1;
    REDIRECT_PC = 32'h300;
    tick();
    REDIRECT = 1'b0;
    tests_run++; if (INSTR_VALID !== 1'b0 || IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h300) begin fails++; $display("FAIL rdh_discard got vld %b req %b addr %h exp 0 1 300", INSTR_VALID, IMEM_REQ, IMEM_ADDR); end
  endtask

  task automatic test_wrap();
    REDIRECT = 1'b1;
    REDIRECT_PC = 32'hFFFF_FFFC;
    tick();
    REDIRECT = 1'b0;
    tests_run++; if (IMEM_ADDR !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_top got %h exp fffffffc", IMEM_ADDR); end
    serve(32'hFFFF_FFFC, 1'b1);
    tests_run++;
    if (exp_q.size() == 0) begin fails++; $display("FAIL wrap_sb got empty queue exp entry"); end
    else begin e = exp_q.pop_front(); if (INSTR !== e.ins || INSTR_PC !== e.pc) begin fails++; $display("FAIL wrap_instr got %h@%h exp %h@%h", INSTR, INSTR_PC, e.ins, e.pc); end end
    INSTR_READY = 1'b1;
    tick();
    INSTR_READY = 1'b0;
    tests_run++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h0 || PC !== 32'h0) begin fails++; $display("FAIL wrap_zero got req %b addr %h pc %h exp 1 0 0", IMEM_REQ, IMEM_ADDR, PC); end
  endtask

  task automatic test_reset_mid();
    REDIRECT = 1'b1;
    REDIRECT_PC = 32'h40;
    tick();
    REDIRECT = 1'b0;
    IMEM_GNT = 1'b1;
    tick();
    IMEM_GNT = 1'b0;
    RST_N = 1'b0;
    #1;
    tests_run++; if (IMEM_REQ !== 1'b0 || IMEM_ADDR !== 32'h0 || PC !== 32'h0) begin fails++; $display("FAIL rstmid_pc got req %b addr %h pc %h exp 0 0 0", IMEM_REQ, IMEM_ADDR, PC); end
    tests_run++; if (INSTR_VALID !== 1'b0 || INSTR !== 32'h0 || INSTR_PC !== 32'h0 || MISALIGN !== 1'b0) begin fails++; $display("FAIL rstmid_instr got vld %b %h@%h mis %b exp 0 0@0 0", INSTR_VALID, INSTR, INSTR_PC, MISALIGN); end
    tick();
    RST_N = 1'b1;
    IMEM_RVALID = 1'b1;
    IMEM_RDATA = 32'hDEAD_BEEF;
    tick();
    IMEM_RVALID = 1'b0;
    tests_run++; if (INSTR_VALID !== 1'b0 || IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h0) begin fails++; $display("FAIL rstmid_late got vld %b req %b addr %h exp 0 1 0", INSTR_VALID, IMEM_REQ, IMEM_ADDR); end
    tick();
    tests_run++; if (INSTR_VALID !== 1'b0 || INSTR !== 32'h0 || IMEM_REQ !== 1'b1) begin fails++; $display("FAIL rstmid_idle got vld %b instr %h req %b exp 0 0 1", INSTR_VALID, INSTR, IMEM_REQ); end
  endtask

  task automatic test_misalign();
    REDIRECT = 1'b1;
    REDIRECT_PC = 32'h102;
    tick();
    REDIRECT = 1'b0;
`ifdef IMEM_FETCH_MISALIGN_EN
    tests_run++; if (MISALIGN !== 1'b1 || IMEM_REQ !== 1'b0 || INSTR_VALID !== 1'b0) begin fails++; $display("FAIL mis_fault got mis %b req %b vld %b exp 1 0 0", MISALIGN, IMEM_REQ, INSTR_VALID); end
    tick();
    tick();
    tests_run++; if (MISALIGN !== 1'b1 || IMEM_REQ !== 1'b0) begin fails++; $display("FAIL mis_stay got mis %b req %b exp 1 0", MISALIGN, IMEM_REQ); end
    REDIRECT = 1'b1;
    REDIRECT_PC = 32'h104;
    tick();
    REDIRECT = 1'b0;
    tests_run++; if (MISALIGN !== 1'b0 || IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h104) begin fails++; $display("FAIL mis_exit got mis %b req %b addr %h exp 0 1 104", MISALIGN, IMEM_REQ, IMEM_ADDR); end
`else
    tests_run++; if (MISALIGN !== 1'b0 || IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h100) begin fails++; $display("FAIL mis_force got mis %b req %b addr %h exp 0 1 100", MISALIGN, IMEM_REQ, IMEM_ADDR); end
`endif
  endtask

  initial begin
    RST_N = 1'b0;
    REDIRECT = 1'b0;
    REDIRECT_PC = 32'h0;
    IMEM_GNT = 1'b0;
    IMEM_RVALID = 1'b0;
    IMEM_RDATA = 32'h0;
    INSTR_READY = 1'b0;
    tick();
    tick();
    test_reset();
    test_stream();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_gnt();
    test_wrap();
    test_reset_mid();
    test_misalign();
    tests_run++; if (exp_q.size() != 0) begin fails++; $display("FAIL sb_leftover got %0d entries exp 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
